vga_sync_gen: RTL
=================

VGA_SYNC_GEN -- requirements
Module: vga_sync_gen

Interface
REQ-001 Parameters SHALL be:
- H_DISPLAY, 640, visible pixels per line
- H_FP, 16, horizontal front porch
- H_SYNC, 96, hsync pulse width
- H_BP, 48, horizontal back porch
- V_DISPLAY, 480, visible lines
- V_FP, 10, vertical front porch
- V_SYNC, 2, vsync pulse width
- V_BP, 33, vertical back porch
REQ-002 The design SHALL have one clock. Reset SHALL be synchronous and active-high. All outputs SHALL be registered or decoded from registers, with no combinational path from rst.
REQ-003 Ports SHALL be:
- clk, in, 1, system clock at 50 MHz
- rst, in, 1, synchronous active-high reset
- hsync, out, 1, horizontal sync, active low
- vsync, out, 1, vertical sync, active low
- video_on, out, 1, high while (pixel_x, pixel_y) is in the visible area
- p_tick, out, 1, pixel-enable strobe at clk/2
- pixel_x, out, 10, current column, 0..H_TOTAL-1
- pixel_y, out, 10, current row, 0..V_TOTAL-1
- frame_tick, out, 1, one-clk pulse on the last pixel of each frame

Function
REQ-004 Derived totals SHALL be:
- H_TOTAL = H_DISPLAY + H_FP + H_SYNC + H_BP, which is 800 with the defaults.
- V_TOTAL = V_DISPLAY + V_FP + V_SYNC + V_BP, which is 525 with the defaults.
REQ-005 A 1-bit divider register SHALL toggle every clk, and p_tick SHALL equal that register. p_tick therefore reads 0,1,0,1,... starting at 0 on the first cycle after reset.
REQ-006 The horizontal counter pixel_x SHALL advance only on clk edges where p_tick=1.
- When advancing, it SHALL increment by 1.
- At H_TOTAL-1 it SHALL wrap to 0.
REQ-007 The vertical counter pixel_y SHALL advance only on edges where p_tick=1 and pixel_x=H_TOTAL-1.
- When advancing, it SHALL increment by 1.
- At V_TOTAL-1 it SHALL wrap to 0.
- Both counters SHALL wrap together at (H_TOTAL-1, V_TOTAL-1).
REQ-008 Each pixel_x value SHALL be held for exactly 2 clks. A line SHALL last 1600 clks and a frame 840000 clks.
REQ-009 hsync SHALL be 0 exactly when H_DISPLAY+H_FP ≤ pixel_x ≤ H_DISPLAY+H_FP+H_SYNC-1, i.e. 656..751. It SHALL be 1 otherwise.
REQ-010 vsync SHALL be 0 exactly when V_DISPLAY+V_FP ≤ pixel_y ≤ V_DISPLAY+V_FP+V_SYNC-1, i.e. 490..491. It SHALL be 1 otherwise.
REQ-011 video_on SHALL be 1 exactly when pixel_x < H_DISPLAY and pixel_y < V_DISPLAY.
REQ-012 hsync, vsync and video_on SHALL be registered and computed from the next counter values. They SHALL therefore change on the same clk edge as the counter value they describe, with zero cycles of skew versus pixel_x/pixel_y.
REQ-013 frame_tick SHALL be 1 for exactly one clk: the cycle in which p_tick=1, pixel_x=H_TOTAL-1 and pixel_y=V_TOTAL-1. It SHALL be 0 otherwise.
REQ-014 Counter arithmetic SHALL be unsigned 10-bit. Counters SHALL never hold a value ≥ the corresponding total.
REQ-015 The block SHALL have no input handshake. Downstream logic (pixel generation, paddle and ball update) SHALL qualify on p_tick and frame_tick.

Reset
REQ-016 While rst=1 at a clk edge, the following SHALL be loaded: divider=0, pixel_x=0, pixel_y=0, hsync=1, vsync=1, video_on=1, frame_tick=0.
REQ-017 Reset asserted mid-line or mid-frame SHALL take effect on the next edge, overriding any pending advance or wrap. No partial sync pulse SHALL persist after that edge.
REQ-018 On the first edge with rst=0, the divider SHALL go to 1. The first pixel_x increment SHALL occur on the second edge after release.

Verification
REQ-019 Reset: rst=1 for 3 clks, then released. Required: pixel_x=0, pixel_y=0, hsync=1, vsync=1, video_on=1, frame_tick=0. After release, p_tick SHALL read 0,1,0,1 and pixel_x SHALL read 0,0,1,1,2.
REQ-020 Line timing:
- hsync SHALL fall on the edge where pixel_x becomes 656 and rise on the edge where it becomes 752, giving 192 clks low.
- video_on SHALL fall when pixel_x becomes 640 and rise at 0.
- After 799, pixel_x SHALL wrap to 0 and pixel_y SHALL go 0→1 on the same edge.
REQ-021 Frame timing:
- vsync SHALL be low while pixel_y is 490..491, which is 3200 clks.
- pixel_y SHALL wrap 524→0.
- frame_tick pulses SHALL be exactly 840000 clks apart, each 1 clk wide.
REQ-022 Mid-frame reset: pulse rst for 1 clk at pixel_x=700, pixel_y=491, which is inside both sync pulses. On the next edge, hsync and vsync SHALL be 1 and the counters SHALL be 0. Counting SHALL then resume per REQ-018.
REQ-023 Invariant checks over 2 full frames:
- pixel_x < 800 and pixel_y < 525 at all times.
- No pixel_x change on any edge where p_tick=0.
- Exactly 480 lines per frame contain any video_on=1 cycles.
REQ-024 Parameter override: instantiate with H_DISPLAY=8, H_FP=2, H_SYNC=2, H_BP=2, V_DISPLAY=4, V_FP=1, V_SYNC=1, V_BP=1. Required:
- hsync low for pixel_x 10..11.
- vsync low for pixel_y 5.
- frame_tick period 14*7*2=196 clks.

Source files
------------

// File: rtl/vga_sync_gen.sv
// VGA raster timing generator: pixel-enable divider, x/y raster counters and
// registered sync/blanking decode aligned with the counters they describe.
module vga_sync_gen #(
  parameter int H_DISPLAY = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_DISPLAY = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33
) (
  input  logic       clk,
  input  logic       rst,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic       p_tick,
  output logic [9:0] pixel_x,
  output logic [9:0] pixel_y,
  output logic       frame_tick
);

  localparam int H_TOTAL = H_DISPLAY + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_DISPLAY + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(H_DISPLAY);
  localparam logic [9:0] V_VIS    = 10'(V_DISPLAY);
  localparam logic [9:0] HS_FIRST = 10'(H_DISPLAY + H_FP);
  localparam logic [9:0] HS_LAST  = 10'(H_DISPLAY + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_FIRST = 10'(V_DISPLAY + V_FP);
  localparam logic [9:0] VS_LAST  = 10'(V_DISPLAY + V_FP + V_SYNC - 1);

  function automatic logic in_range(input logic [9:0] v, input logic [9:0] lo,
                                    input logic [9:0] hi);
    return (v >= lo) && (v <= hi);
  endfunction

  logic       div_q;
  logic [9:0] x_q, y_q;
  logic [9:0] x_nxt, y_nxt;
  logic       hsync_q, vsync_q, von_q;

  // Next raster position; sync decode below uses it so outputs stay aligned.
  always_comb begin
    x_nxt = x_q;
    y_nxt = y_q;
    if (div_q) begin
      if (x_q == H_LAST) begin
        x_nxt = '0;
        y_nxt = (y_q == V_LAST) ? '0 : y_q + 10'd1;
      end else begin
        x_nxt = x_q + 10'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_q   <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
      hsync_q <= 1'b1;
      vsync_q <= 1'b1;
      von_q   <= 1'b1;
    end else begin
      div_q   <= ~div_q;
      x_q     <= x_nxt;
      y_q     <= y_nxt;
      hsync_q <= ~in_range(x_nxt, HS_FIRST, HS_LAST);
      vsync_q <= ~in_range(y_nxt, VS_FIRST, VS_LAST);
      von_q   <= (x_nxt < H_VIS) && (y_nxt < V_VIS);
    end
  end

  assign p_tick     = div_q;
  assign pixel_x    = x_q;
  assign pixel_y    = y_q;
  assign hsync      = hsync_q;
  assign vsync      = vsync_q;
  assign video_on   = von_q;
  // Last pixel-enable of the frame; div_q is 0 during reset so this stays low.
  assign frame_tick = div_q & (x_q == H_LAST) & (y_q == V_LAST);

endmodule
